// File: rtl/imem_loader_ctrl.sv
// Boot loader for the instruction memory: packs a byte stream into big-endian words, writes them
// sequentially and arbitrates the read port with CPU fetch. Optional readback check: IMEM_VERIFY_EN.
module imem_loader_ctrl #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_d,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_dpra,
    input  logic [31:0]       mem_dpo,
    input  logic [ADDR_W-1:0] cpu_pc_addr,
    output logic [31:0]       cpu_instr,
    output logic              cpu_stall,
    output logic              busy,
    output logic              load_done,
    output logic              verify_err
);

    localparam logic [ADDR_W-1:0] Base = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] One  = ADDR_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
`ifdef IMEM_VERIFY_EN
        StVerify,
`endif
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Only the first three bytes need holding; the fourth goes straight into mem_d.
    logic [23:0]       word_q, word_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [31:0]       mem_d_q, mem_d_d;
    logic [ADDR_W-1:0] verify_addr;

`ifdef IMEM_VERIFY_EN
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [31:0]       wsum_q, wsum_d;
    logic [31:0]       rsum_q, rsum_d;
    logic              verr_q, verr_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            mem_a_q    <= '0;
            mem_d_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            mem_a_q    <= mem_a_d;
            mem_d_q    <= mem_d_d;
        end
    end

`ifdef IMEM_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wsum_q   <= '0;
            rsum_q   <= '0;
            verr_q   <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wsum_q   <= wsum_d;
            rsum_q   <= rsum_d;
            verr_q   <= verr_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_a_d     = mem_a_q;
        mem_d_d     = mem_d_q;
        byte_ready  = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b0;
        load_done   = 1'b0;
        verify_addr = '0;
`ifdef IMEM_VERIFY_EN
        rd_cnt_d    = rd_cnt_q;
        wsum_d      = wsum_q;
        rsum_d      = rsum_q;
        verr_d      = verr_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
`ifdef IMEM_VERIFY_EN
                    verr_d = 1'b0;
`endif
                    if (load_len != '0) begin
                        len_d      = load_len;
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
`ifdef IMEM_VERIFY_EN
                        wsum_d     = '0;
`endif
                        state_d    = StLoad;
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StLoad: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: word_d[23:16] = byte_in;
                        2'd1: word_d[15:8]  = byte_in;
                        2'd2: word_d[7:0]   = byte_in;
                        2'd3: begin
                            // Register the write so mem_a/mem_d stay put outside WRITE.
                            mem_a_d = Base + word_cnt_q;
                            mem_d_d = {word_q, byte_in};
                            state_d = StWrite;
                        end
                    endcase
                end
            end

            StWrite: begin
                busy   = 1'b1;
                mem_we = 1'b1;
`ifdef IMEM_VERIFY_EN
                wsum_d = wsum_q ^ mem_d_q;
`endif
                if (word_cnt_q == len_q - One) begin
`ifdef IMEM_VERIFY_EN
                    rd_cnt_d = '0;
                    rsum_d   = '0;
                    state_d  = StVerify;
`else
                    state_d  = StDone;
`endif
                end else begin
                    word_cnt_d = word_cnt_q + One;
                    byte_cnt_d = '0;
                    state_d    = StLoad;
                end
            end

`ifdef IMEM_VERIFY_EN
            StVerify: begin
                busy        = 1'b1;
                verify_addr = Base + rd_cnt_q;
                rsum_d      = rsum_q ^ mem_dpo;
                rd_cnt_d    = rd_cnt_q + One;
                if (rd_cnt_q == len_q - One) begin
                    if (rsum_d != wsum_q) begin
                        verr_d = 1'b1;
                    end
                    state_d = StDone;
                end
            end
`endif

            StDone: begin
                load_done = 1'b1;
                state_d   = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    assign mem_a     = mem_a_q;
    assign mem_d     = mem_d_q;
    assign cpu_stall = busy;
    // While stalled the CPU sees a NOP and the read port belongs to the loader.
    assign mem_dpra  = busy ? verify_addr : cpu_pc_addr;
    assign cpu_instr = busy ? 32'h0000_0000 : mem_dpo;

`ifdef IMEM_VERIFY_EN
    assign verify_err = verr_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule
